// File: rtl/cmp_pkg.sv
// Shared types for the shared-comparator arbiter: FSM states, the result triple,
// and the default operand width.
package cmp_pkg;

  localparam int CMP_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned magnitude comparator; width is parameterized but defaults to 4 bits.
module comparator_4bit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, with wrap.
// The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  always_comb begin
    int idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    // Walk from farthest to nearest so the closest hit to ptr is the one that sticks.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin front end that time-shares one magnitude comparator between NUM_REQ
// requesters and returns a registered gt/eq/lt result tagged with the requester ID.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = CMP_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_gt,
  output logic                      rsp_eq,
  output logic                      rsp_lt,
  output logic                      busy,
  output logic [15:0]               op_count
);

  cmp_state_t          state, nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [DATA_W-1:0]   sel_a, sel_b;
  cmp_res_t            res_q, cmp_res;
  logic                rsp_valid_q;
  logic [15:0]         cnt_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                any;
  logic                accept, handshake;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  comparator_4bit #(.W(DATA_W)) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .gt (cmp_res.gt),
    .eq (cmp_res.eq),
    .lt (cmp_res.lt)
  );

  always_comb begin
    sel_a = req_a[int'(gnt_id)*DATA_W +: DATA_W];
    sel_b = req_b[int'(gnt_id)*DATA_W +: DATA_W];
  end

  always_comb begin
    nxt       = state;
    req_ready = '0;
    accept    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: if (any) begin
        // Masked by rst so no accept pulse escapes while reset is held.
        req_ready = rst ? '0 : gnt;
        accept    = 1'b1;
        nxt       = CMP;
      end
      CMP:  nxt = RESP;
      RESP: if (rsp_ready) begin
        handshake = 1'b1;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      id_q        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_a <= sel_a;
        op_b <= sel_b;
        id_q <= gnt_id;
      end
      if (state == CMP) begin
        res_q       <= cmp_res;
        rsp_valid_q <= 1'b1;
      end
      if (handshake) begin
        rr_ptr      <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        cnt_q       <= cnt_q + 16'd1;
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_gt    = res_q.gt;
  assign rsp_eq    = res_q.eq;
  assign rsp_lt    = res_q.lt;
  assign busy      = (state != IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: reset, single-requester results, round-robin order,
// backpressure, mid-transaction reset and op_count wrap.
module tb_cmp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_gt, rsp_eq, rsp_lt, busy;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;

  cmp_arbiter #(.NUM_REQ(4), .DATA_W(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; all driving and sampling is mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = 1'($urandom);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy, op_count} !== 27'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: rdy=%b vld=%b id=%0d g/e/l=%b%b%b busy=%b cnt=%0d want all 0",
                 i, req_ready, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, busy, op_count);
      end
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b0;
    cyc();
    checks++;
    if ({req_ready, busy, rsp_valid} !== 6'd0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b vld=%b want 0", req_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_single();
    logic [3:0] av [3];
    logic [3:0] bv [3];
    logic [2:0] ev [3];
    av = '{4'd9, 4'd7, 4'd0};
    bv = '{4'd3, 4'd7, 4'd15};
    ev = '{3'b100, 3'b010, 3'b001};
    for (int t = 0; t < 3; t++) begin
      req_a = '0; req_b = '0;
      req_a[11:8] = av[t];
      req_b[11:8] = bv[t];
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL single%0d_accept: req_ready=%b want 0100", t, req_ready);
      end
      cyc();
      req_valid = '0;
      req_a[11:8] = ~av[t];
      #1;
      checks++;
      if ({busy, rsp_valid, req_ready} !== 6'b100000) begin
        errors++;
        $display("FAIL single%0d_cmp: busy=%b vld=%b rdy=%b want 1,0,0000", t, busy, rsp_valid, req_ready);
      end
      cyc();
      checks++;
      if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'd2, ev[t]}) begin
        errors++;
        $display("FAIL single%0d_rsp: vld=%b id=%0d gel=%b%b%b want 1,2,%b",
                 t, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, ev[t]);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, busy, op_count} !== {2'b00, 16'(t + 1)}) begin
        errors++;
        $display("FAIL single%0d_done: vld=%b busy=%b cnt=%0d want 0,0,%0d", t, rsp_valid, busy, op_count, t + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] ev [4];
    ev = '{3'b010, 3'b001, 3'b100, 3'b010};
    do_reset();
    req_a = {4'd2, 4'd8, 4'd5, 4'd3};
    req_b = {4'd2, 4'd1, 4'd9, 4'd3};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_ready !== 4'(1 << (i % 4))) begin
        errors++;
        $display("FAIL rr_grant%0d: req_ready=%b want %b", i, req_ready, 4'(1 << (i % 4)));
      end
      cyc();
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rr_cmp_ready%0d: req_ready=%b want 0000", i, req_ready);
      end
      cyc();
      checks++;
      if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'(i % 4), ev[i % 4]}) begin
        errors++;
        $display("FAIL rr_rsp%0d: vld=%b id=%0d gel=%b%b%b want 1,%0d,%b",
                 i, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, i % 4, ev[i % 4]);
      end
      cyc();
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== 16'd5) begin
      errors++;
      $display("FAIL rr_count: op_count=%0d want 5", op_count);
    end
  endtask

  task automatic test_backpressure();
    // rr_ptr is 1 here; requesters 1..3 pending, 1 wins.
    req_a = {4'd1, 4'd1, 4'd6, 4'd0};
    req_b = {4'd1, 4'd2, 4'd4, 4'd0};
    req_valid = 4'b1110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_accept: req_ready=%b want 0010", req_ready);
    end
    cyc();
    req_valid = 4'b1100;
    req_a[7:4] = 4'd0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, req_ready, busy} !== {1'b1, 2'd1, 3'b100, 4'b0000, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b id=%0d gel=%b%b%b rdy=%b busy=%b want 1,1,100,0000,1",
                 i, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt, req_ready, busy);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    #1;
    checks++;
    if ({req_ready, op_count} !== {4'b0100, 16'd6}) begin
      errors++;
      $display("FAIL bp_next_grant: rdy=%b cnt=%0d want 0100,6", req_ready, op_count);
    end
    cyc();
    req_valid = 4'b1000;
    cyc();
    checks++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'd2, 3'b001}) begin
      errors++;
      $display("FAIL bp_req2_rsp: vld=%b id=%0d gel=%b%b%b want 1,2,001", rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt);
    end
    req_valid = '0;
    cyc();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (op_count !== 16'd7) begin
      errors++;
      $display("FAIL bp_count: op_count=%0d want 7", op_count);
    end
  endtask

  task automatic test_mid_reset();
    // rr_ptr is 3: with 0 and 3 pending, 3 wins before reset and 0 after.
    req_a = {4'd4, 4'd0, 4'd0, 4'd2};
    req_b = {4'd5, 4'd0, 4'd0, 4'd2};
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL mr_pre_accept: req_ready=%b want 1000", req_ready);
    end
    cyc();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rsp_valid, busy, req_ready, op_count} !== 22'd0) begin
        errors++;
        $display("FAIL mr_in_reset%0d: vld=%b busy=%b rdy=%b cnt=%0d want 0", i, rsp_valid, busy, req_ready, op_count);
      end
      cyc();
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mr_reaccept: req_ready=%b want 0001", req_ready);
    end
    cyc();
    req_valid = '0;
    cyc();
    checks++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt} !== {1'b1, 2'd0, 3'b010}) begin
      errors++;
      $display("FAIL mr_rsp: vld=%b id=%0d gel=%b%b%b want 1,0,010", rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (op_count !== 16'd1) begin
      errors++;
      $display("FAIL mr_count: op_count=%0d want 1", op_count);
    end
  endtask

  task automatic test_count_wrap();
    logic [15:0] ev [2];
    ev = '{16'hFFFF, 16'h0000};
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    #1;
    checks++;
    if (op_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_preload: op_count=%h want fffe", op_count);
    end
    req_a = 16'h1111;
    req_b = 16'h2222;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      cyc();
      cyc();
      #1;
      checks++;
      if (op_count !== ev[i]) begin
        errors++;
        $display("FAIL wrap_step%0d: op_count=%h want %h", i, op_count, ev[i]);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    cyc();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares one 4-bit magnitude comparator datapath between `NUM_REQ` requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The block latches the winning pair, runs it through the comparator, and returns a registered three-way result on a single response channel tagged with the requester ID. It sits between client blocks and the comparator instance so that only one comparator is needed per cluster.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `DATA_W`, default 4: operand width; must match the comparator instance.
- `ID_W`, default 2: width of the response ID, equal to $clog2(NUM_REQ).

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  one bit per requester; high means an operand pair is offered.
- `req_a`  in  NUM_REQ*DATA_W  flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_b`  in  NUM_REQ*DATA_W  flattened operand B, same packing as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot accept pulse; at most one bit high per cycle.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that owns the result.
- `rsp_gt`, `rsp_eq`, `rsp_lt`  out  1 each  A>B, A==B, A<B; exactly one is high while `rsp_valid` is high.
- `busy`  out  1  high in every state except IDLE.
- `op_count`  out  16  number of completed transactions.

## Operation
The FSM has three states: IDLE, CMP, RESP.
- **IDLE**
  - If any `req_valid` bit is high, the arbiter selects the first valid index at or after `rr_ptr`, searching upward with wrap.
  - In the same cycle: assert `req_ready[sel]`, latch `req_a[sel]` and `req_b[sel]` into the operand registers, latch `sel` into the ID register, and move to CMP.
  - If no `req_valid` bit is high, stay in IDLE.
- **CMP**
  - Register the comparator outputs into the `rsp_gt`, `rsp_eq` and `rsp_lt` registers.
  - Set `rsp_valid`=1 and move to RESP.
- **RESP**
  - Hold `rsp_valid` and all response fields stable until `rsp_ready`=1.
  - On the handshake:
    - set `rr_ptr` to (ID+1) mod NUM_REQ;
    - increment `op_count` (it wraps from 0xFFFF to 0);
    - clear `rsp_valid`;
    - return to IDLE.
- **Fairness:** after a requester is served it has the lowest priority. A requester that holds `req_valid` high is served within NUM_REQ transactions.
- **Comparison:** unsigned, full `DATA_W` width, with no sign extension.
- **Handshake rules:**
  - A requester must hold `req_valid`, `req_a` and `req_b` stable until it sees `req_ready`.
  - Deasserting `req_valid` before acceptance is legal and has no side effects.
  - Operands are sampled only in the accept cycle, so later changes do not affect an in-flight result.
- **Outputs outside the accept cycle:**
  - `req_ready` is all zeros in CMP and RESP.
  - `req_ready` is all zeros in IDLE when no request is valid.
  - `req_ready` is never high for a requester whose `req_valid` is low.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_gt`/`rsp_eq`/`rsp_lt`=0, `busy`=0, `op_count`=0, `rr_ptr`=0, state=IDLE.
- Latency: accept in cycle T, `rsp_valid` high from cycle T+2.
- Maximum throughput is one transaction every 3 cycles with `rsp_ready` held high. The handshake cycle returns to IDLE, so the next accept happens at T+3 at the earliest.
- Simultaneous requests are resolved entirely by `rr_ptr`; losers stay pending and are not acknowledged.
- Requests arriving while `busy`=1 are ignored until IDLE.
- `rsp_ready` is a don't-care outside RESP.
- When `rst` asserts mid-transaction, everything returns to reset values immediately and the in-flight result is discarded. No `req_ready` or `rsp_valid` is emitted for it.
- The `op_count` register is only written on the RESP handshake.

## Structure
- Shared package `cmp_pkg`, containing:
  - the FSM state enum `cmp_state_t` (IDLE, CMP, RESP);
  - the result struct `cmp_res_t` {gt, eq, lt};
  - the default `DATA_W` constant.
- Sub-module `rr_arbiter`: a combinational round-robin pick.
  - Inputs: `req` [NUM_REQ], `ptr` [ID_W].
  - Outputs: one-hot `gnt`, encoded `gnt_id`, `any`.
  - `rr_ptr` is owned by `cmp_arbiter`, not by `rr_arbiter`.
- The comparator is instantiated as the team's existing `comparator_4bit`, fed from the operand registers. It is the only comparison logic in the block.

## Test plan
- **Reset state:** hold `rst` and drive random inputs. Expect all outputs at their reset values, then no `req_ready` until `rst` drops.
- **Single requester, all three results:**
  - Req 2 with A=9, B=3: `req_ready`=4'b0100 at T; at T+2, `rsp_valid`=1, `rsp_id`=2, `rsp_gt`=1.
  - Repeat with A=7, B=7, expecting `rsp_eq`=1.
  - Repeat with A=0, B=15, expecting `rsp_lt`=1.
- **Round-robin:** all four requesters valid with `rsp_ready`=1. Expect grants in the order 0,1,2,3,0 at 3-cycle intervals and `op_count`=5.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles with req 1 complete. Expect `rsp_valid` and the fields held stable, `req_ready`=0 even with other requests pending. When `rsp_ready`=1, expect the next grant to go to req 2 (`rr_ptr` was 2).
- **Mid-operation reset:** assert `rst` in CMP. Expect `rsp_valid` never to rise and `op_count`=0 after release. The pending request is re-accepted from `rr_ptr`=0.
- **Counter wrap:** force 65536 transactions (or preload via backdoor). Expect `op_count` to go from 0xFFFF to 0.
